// File: rtl/inst_queue_if.sv
// inst_queue_if
//   Bundles the fetch-side and decode-side signals of the halfword
//   instruction queue.
//   slave  : the queue itself. It receives the memory word, the flush
//            and the consume count, and drives the decoder view and status.
//   master : the surrounding core, meaning the fetcher and the decoder.
//
//   Signals
//     from_memory         32       fetched word; [15:0] older, [31:16] younger
//     mem_valid           1        from_memory carries a new word
//     flush               1        branch redirect
//     flush_pc            16       halfword address of redirect target
//     num_items_consumed  2        entries retired by decoder (0..2)
//     first_inst          16       oldest entry (0 when not valid)
//     second_inst         16       next-oldest entry (0 when not valid)
//     first_valid         1        first_inst meaningful
//     second_valid        1        second_inst meaningful
//     first_pc            16       halfword address of first_inst
//     count               PTR_W+1  occupancy
//     should_memory_stall 1        fetcher must hold its address
//     overflow_err        1        sticky dropped-push flag
interface inst_queue_if #(
  parameter int PTR_W = 3
) ();

  logic [31:0]      from_memory;
  logic             mem_valid;
  logic             flush;
  logic [15:0]      flush_pc;
  logic [1:0]       num_items_consumed;
  logic [15:0]      first_inst;
  logic [15:0]      second_inst;
  logic             first_valid;
  logic             second_valid;
  logic [15:0]      first_pc;
  logic [PTR_W:0]   count;
  logic             should_memory_stall;
  logic             overflow_err;

  modport slave (
    input  from_memory, mem_valid, flush, flush_pc, num_items_consumed,
    output first_inst, second_inst, first_valid, second_valid, first_pc,
           count, should_memory_stall, overflow_err
  );

  modport master (
    output from_memory, mem_valid, flush, flush_pc, num_items_consumed,
    input  first_inst, second_inst, first_valid, second_valid, first_pc,
           count, should_memory_stall, overflow_err
  );

endinterface

// File: rtl/inst_queue.sv
// inst_queue
//   This is a halfword instruction queue placed between instruction RAM
//   port A and the dual-issue decoder. Each 32-bit memory word is split
//   into two entries. The low half is the older entry, and the high half
//   is the younger one.
//   The queue presents its two oldest entries and retires 0, 1 or 2 of
//   them per cycle. It raises a stall request early enough to absorb one
//   word that is already in flight. A flush empties the queue.
//
//   Ports
//     clk          core clock; all state updates on posedge
//     CPU_RESET_n  asynchronous active-low reset
//     q            inst_queue_if.slave (see inst_queue_if for signals)
//
//   Optional build macro INST_QUEUE_BYPASS_EN
//     When this macro is defined and the queue is empty, an arriving word
//     (with no discard pending) is forwarded combinationally to
//     first/second in the same cycle. Entries consumed in that cycle are
//     never written, and the remainder is enqueued.
//     When the macro is not defined, there is no combinational path from
//     from_memory to the outputs.
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic         clk,
  input  logic         CPU_RESET_n,
  inst_queue_if.slave  q
);

  localparam int CW = PTR_W + 1;

  logic [15:0]    mem [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CW-1:0]  count_q;
  logic [15:0]    first_pc_q;
  logic           overflow_q;
  logic           drop_low_q;
  logic           discard_q;

  logic [15:0]    lo_half, hi_half;
  logic [1:0]     req, eff, eff_q, eff_w;
  logic [1:0]     push_size, push_len, start_idx;
  logic [CW-1:0]  avail, space;
  logic           push_req, push_ok, fits, bypass_hit;
  logic           we0, we1;
  logic [15:0]    wr_data0;
  logic [PTR_W-1:0] head_p1, tail_p1;

  assign lo_half = q.from_memory[15:0];
  assign hi_half = q.from_memory[31:16];
  assign head_p1 = head_q + PTR_W'(1);
  assign tail_p1 = tail_q + PTR_W'(1);

  always_comb begin
    req        = (q.num_items_consumed == 2'd3) ? 2'd2 : q.num_items_consumed;
    // The word arriving the cycle after a flush was fetched from the old
    // path and is discarded.
    push_req   = q.mem_valid && !discard_q && !q.flush;
    push_size  = drop_low_q ? 2'd1 : 2'd2;
`ifdef INST_QUEUE_BYPASS_EN
    bypass_hit = push_req && (count_q == '0);
`else
    bypass_hit = 1'b0;
`endif
    // In bypass, the decoder can only retire entries from the incoming word.
    avail      = bypass_hit ? CW'(push_size) : count_q;
    eff        = (CW'(req) > avail) ? avail[1:0] : req;
    eff_q      = bypass_hit ? 2'd0 : eff;
    eff_w      = bypass_hit ? eff : 2'd0;
    push_len   = push_size - eff_w;
    // Free space is measured after this cycle's consume, so a full queue
    // that is retiring 2 entries can still accept a word.
    space      = CW'(DEPTH) - count_q + CW'(eff_q);
    fits       = CW'(push_len) <= space;
    push_ok    = push_req && fits;
    // start_idx is the first half of the word that is actually stored.
    start_idx  = 2'(drop_low_q) + eff_w;
    wr_data0   = (start_idx == 2'd0) ? lo_half : hi_half;
    we0        = push_ok && (push_len != 2'd0);
    we1        = push_ok && (push_len == 2'd2);
  end

  always_ff @(posedge clk or negedge CPU_RESET_n) begin
    if (!CPU_RESET_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      first_pc_q <= '0;
      overflow_q <= 1'b0;
      drop_low_q <= 1'b0;
      discard_q  <= 1'b0;
    end else if (q.flush) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      first_pc_q <= q.flush_pc;
      drop_low_q <= q.flush_pc[0];
      discard_q  <= 1'b1;
    end else begin
      discard_q  <= 1'b0;
      head_q     <= head_q + PTR_W'(eff_q);
      first_pc_q <= first_pc_q + 16'(eff);
      if (push_ok) begin
        tail_q  <= tail_q + PTR_W'(push_len);
        count_q <= count_q - CW'(eff_q) + CW'(push_len);
      end else begin
        count_q <= count_q - CW'(eff_q);
      end
      if (push_req) begin
        drop_low_q <= 1'b0;
        if (!fits) overflow_q <= 1'b1;
      end
    end
  end

  // The storage needs no reset, because the outputs are gated by count.
  always_ff @(posedge clk) begin
    if (CPU_RESET_n && !q.flush) begin
      if (we0) mem[tail_q]  <= wr_data0;
      if (we1) mem[tail_p1] <= hi_half;
    end
  end

  always_comb begin
    q.first_inst   = 16'h0000;
    q.second_inst  = 16'h0000;
    q.first_valid  = 1'b0;
    q.second_valid = 1'b0;
    if (bypass_hit) begin
      q.first_valid  = 1'b1;
      q.first_inst   = drop_low_q ? hi_half : lo_half;
      q.second_valid = !drop_low_q;
      q.second_inst  = drop_low_q ? 16'h0000 : hi_half;
    end else begin
      if (count_q >= CW'(1)) begin
        q.first_valid = 1'b1;
        q.first_inst  = mem[head_q];
      end
      if (count_q >= CW'(2)) begin
        q.second_valid = 1'b1;
        q.second_inst  = mem[head_p1];
      end
    end
    q.first_pc            = first_pc_q;
    q.count               = count_q;
    // Stall is asserted with a 4-entry margin, so that the word already
    // leaving the registered RAM output still fits.
    q.should_memory_stall = count_q > CW'(DEPTH - 4);
    q.overflow_err        = overflow_q;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Halfword instruction queue between instruction RAM port A and the dual-issue decoder.
- Accepts 32-bit memory words. The low 16 bits form the older instruction and go to the first slot; the high 16 bits form the younger instruction.
- Presents the two oldest instructions to the decoder as first/second and retires 0, 1 or 2 per cycle according to the decoder's consume count.
- Raises a memory-stall request early enough to absorb RAM read latency, and flushes on branch redirect.

Parameters:
- DEPTH, 8, queue capacity in 16-bit entries; power of two, minimum 4.
- PTR_W, 3, log2(DEPTH); pointer width.

Ports:
- clk  in  1  core clock, single-stepped from the key; all state updates on posedge.
- CPU_RESET_n  in  1  asynchronous active-low reset.
- from_memory  in  32  fetched word; [15:0] is older, [31:16] is younger.
- mem_valid  in  1  from_memory carries a new word this cycle.
- flush  in  1  branch redirect; discard all contents and any in-flight word.
- flush_pc  in  16  halfword address of the redirect target.
- num_items_consumed  in  2  entries the decoder retires this cycle (0..2; 3 is illegal).
- first_inst  out  16  oldest entry; 0 when not valid.
- second_inst  out  16  next-oldest entry; 0 when not valid.
- first_valid  out  1  first_inst is meaningful.
- second_valid  out  1  second_inst is meaningful.
- first_pc  out  16  halfword address of first_inst.
- count  out  PTR_W+1  current occupancy.
- should_memory_stall  out  1  fetcher must hold its address.
- overflow_err  out  1  sticky; a push was dropped for lack of space.

Behaviour:
- Reset, asynchronous: head = tail = count = 0; first_pc = 0; overflow_err = 0; drop_low = 0. All outputs read 0, except should_memory_stall = 0.
- Storage: circular buffer of DEPTH x 16. Head and tail wrap modulo DEPTH.
- Outputs are combinational from registered state:
  - first = mem[head], second = mem[head+1].
  - first_valid = count >= 1; second_valid = count >= 2.
- Effective consume: eff = min(num_items_consumed, count). A request of 3 is treated as 2. Consuming more than is valid never underflows.
- Push size:
  - 2 entries per mem_valid word.
  - 1 entry (high half only) when drop_low = 1; drop_low then clears.
- Space check uses post-consume space: space = DEPTH - count + eff.
  - If push size > space, the whole word is dropped and overflow_err is set until reset.
  - No partial push.
- Simultaneous push and consume in one cycle is legal:
  - count_next = count - eff + pushed.
  - head += eff; tail += pushed.
  - first_pc += eff.
- should_memory_stall = count > DEPTH-4 (count >= 5 at default), from registered count only.
  - The 4-entry margin absorbs the one word already in flight from the registered RAM output.
  - A word arriving the cycle after stall asserts therefore always fits.
- Flush has priority over everything in that cycle:
  - head = tail = count = 0; first_pc = flush_pc.
  - mem_valid that same cycle is ignored.
  - Flush also sets a one-cycle discard flag, so a mem_valid on the next cycle is ignored (stale in-flight word).
  - drop_low = flush_pc[0]: an odd target discards the low half of the first accepted word.
- Flush coincident with reset: reset wins.
- Latency: a word pushed at edge N is visible on first/second after edge N. Empty-to-visible latency is 1 cycle.

Optional Feature:
- INST_QUEUE_BYPASS_EN.
- Defined:
  - When count == 0, mem_valid = 1 and no discard is pending, first/second are driven combinationally from from_memory in the same cycle, with valids set. drop_low applies.
  - Entries consumed in that cycle are not written; the remainder is enqueued.
- Undefined: no combinational path from from_memory to outputs; 1-cycle latency as above.

Test Plan:
- Reset, then push 0x2222_1111 with consume=0 -> after edge: first_inst=0x1111, second_inst=0x2222, count=2, first_pc=0.
- Push a word every cycle with consume=0 -> should_memory_stall rises when count reaches 6. The in-flight word fills to count=8; a further push sets overflow_err=1 and count stays 8.
- count=2, consume=2 with a simultaneous push of 0xBBBB_AAAA -> count=2, first_inst=0xAAAA, first_pc advanced by 2. Wrap-around across entry 7->0 is checked in the same run.
- count=1, num_items_consumed=2 -> eff=1, count=0, first_valid=0, no underflow.
- flush with flush_pc=0x0011 while mem_valid=1, then the next-cycle word is discarded, then push 0x4444_3333 -> first_inst=0x4444, count=1, first_pc=0x0011.
- Assert CPU_RESET_n low mid-stream at count=5 -> all outputs 0 immediately, without waiting for a clock edge.
